uart_cmd_ctrl: RTL

Command controller between the UART receiver and the CCD acquisition datapath of the apple sugar detector. It consumes the received byte stream over a valid/ready handshake and parses fixed 5-byte command frames. It then issues acquisition start/stop pulses, holds the integration-time configuration, and returns a one-byte response to the UART transmitter. It is the only block allowed to drive CCD sequencing from the host link.

---
 rtl/uart_cmd_pkg.sv | 39 +++
 rtl/uart_cmd_ctrl_if.sv | 31 +++
 rtl/uart_byte_timeout.sv | 43 ++++
 rtl/uart_cmd_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared constants and state type for the host command controller.
// Frame layout on the wire: HDR_BYTE, CMD, ARG_H, ARG_L, CSUM.
package uart_cmd_pkg;

   localparam logic [7:0] HDR_BYTE       = 8'hA5;

   localparam logic [7:0] CMD_START      = 8'h01;
   localparam logic [7:0] CMD_SET_INTEG  = 8'h02;
   localparam logic [7:0] CMD_STOP       = 8'h03;
   localparam logic [7:0] CMD_QUERY      = 8'h04;

   localparam logic [7:0] RSP_ACK        = 8'h06;
   localparam logic [7:0] RSP_NAK        = 8'h15;
   localparam logic [7:0] RSP_QUERY_BASE = 8'h80;

   typedef enum logic [2:0] {
      ST_HUNT  = 3'd0,
      ST_CMD   = 3'd1,
      ST_ARG_H = 3'd2,
      ST_ARG_L = 3'd3,
      ST_CSUM  = 3'd4,
      ST_EXEC  = 3'd5,
      ST_RESP  = 3'd6
   } state_e;

   // States between the header and the checksum, where the byte timeout is armed.
   function automatic logic in_frame(input state_e s);
      return (s == ST_CMD) || (s == ST_ARG_H) || (s == ST_ARG_L) || (s == ST_CSUM);
   endfunction

   function automatic logic accepts_rx(input state_e s);
      return (s == ST_HUNT) || in_frame(s);
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Byte-stream link between the UART pair and the command controller.
// The master side is the UART (RX producer, TX consumer); the slave side is the controller.
interface uart_cmd_ctrl_if;

   logic [7:0] rx_data;
   logic       rx_data_valid;
   logic       rx_data_ready;

   logic [7:0] tx_data;
   logic       tx_data_valid;
   logic       tx_data_ready;

   modport master (
      output rx_data,
      output rx_data_valid,
      input  rx_data_ready,
      input  tx_data,
      input  tx_data_valid,
      output tx_data_ready
   );

   modport slave (
      input  rx_data,
      input  rx_data_valid,
      output rx_data_ready,
      output tx_data,
      output tx_data_valid,
      input  tx_data_ready
   );

endinterface

// File: rtl/uart_byte_timeout.sv
// Inter-byte idle counter: counts enabled cycles since the last clear and emits a
// one-cycle expired pulse on the TIMEOUT_CYC-th idle cycle, restarting from zero.
module uart_byte_timeout #(
   parameter int unsigned TIMEOUT_CYC = 50_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned   CW   = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Clear has priority so a byte landing on the last idle cycle still wins.
   always_comb begin
      cnt_d     = cnt_q;
      expired_o = 1'b0;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         if (cnt_q == LAST) begin
            expired_o = 1'b1;
            cnt_d     = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Host command controller: parses A5-framed commands from the UART receiver, drives the
// CCD start/stop pulses and integration time, and returns a one-byte response.
module uart_cmd_ctrl
   import uart_cmd_pkg::*;
#(
   parameter int unsigned CLK_HZ        = 50_000_000,
   parameter int unsigned TIMEOUT_CYC   = 50_000,
   parameter logic [15:0] INTEG_DEFAULT = 16'd1000
) (
   input  logic           clk_50m,
   input  logic           rst_n,
   uart_cmd_ctrl_if.slave link,
   input  logic           ccd_busy,
   output logic           ccd_start,
   output logic           ccd_stop,
   output logic [15:0]    integ_time,
   output logic [7:0]     err_cnt
);

   if (CLK_HZ == 0 || TIMEOUT_CYC == 0) begin : g_param_check
      $error("uart_cmd_ctrl: CLK_HZ and TIMEOUT_CYC must be non-zero");
   end

   state_e      state_q, state_d;
   logic [7:0]  cmd_q, cmd_d;
   logic [7:0]  argHi_q, argHi_d;
   logic [7:0]  argLo_q, argLo_d;
   logic [7:0]  sum_q, sum_d;
   logic        csumOk_q, csumOk_d;
   logic        rdy_q, rdy_d;
   logic [7:0]  txData_q, txData_d;
   logic        txValid_q, txValid_d;
   logic        start_q, start_d;
   logic        stop_q, stop_d;
   logic [15:0] integ_q, integ_d;
   logic [7:0]  err_q, err_d;

   logic        rxFire;
   logic        txFire;
   logic        tmoEn;
   logic        tmoClr;
   logic        tmoExpired;

   assign rxFire = link.rx_data_valid & rdy_q;
   assign txFire = txValid_q & link.tx_data_ready;
   assign tmoEn  = in_frame(state_q);
   assign tmoClr = rxFire | ~tmoEn;

   uart_byte_timeout #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout (
      .clk       (clk_50m),
      .rst_n     (rst_n),
      .clr_i     (tmoClr),
      .en_i      (tmoEn),
      .expired_o (tmoExpired)
   );

   // Frame parsing, command execution and response hand-off. The checksum is
   // accumulated byte by byte so CSUM only needs a single 8-bit compare.
   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      argHi_d   = argHi_q;
      argLo_d   = argLo_q;
      sum_d     = sum_q;
      csumOk_d  = csumOk_q;
      txData_d  = txData_q;
      txValid_d = txValid_q;
      start_d   = 1'b0;
      stop_d    = 1'b0;
      integ_d   = integ_q;
      err_d     = err_q;

      unique case (state_q)
         ST_HUNT: begin
            if (rxFire && link.rx_data == HDR_BYTE) begin
               state_d = ST_CMD;
            end
         end
         ST_CMD: begin
            if (rxFire) begin
               cmd_d   = link.rx_data;
               sum_d   = link.rx_data;
               state_d = ST_ARG_H;
            end
         end
         ST_ARG_H: begin
            if (rxFire) begin
               argHi_d = link.rx_data;
               sum_d   = sum_q + link.rx_data;
               state_d = ST_ARG_L;
            end
         end
         ST_ARG_L: begin
            if (rxFire) begin
               argLo_d = link.rx_data;
               sum_d   = sum_q + link.rx_data;
               state_d = ST_CSUM;
            end
         end
         ST_CSUM: begin
            if (rxFire) begin
               csumOk_d = (link.rx_data == sum_q);
               state_d  = ST_EXEC;
            end
         end
         ST_EXEC: begin
            txValid_d = 1'b1;
            state_d   = ST_RESP;
            if (!csumOk_q) begin
               txData_d = RSP_NAK;
               err_d    = sat_inc8(err_q);
            end else begin
               case (cmd_q)
                  CMD_START: begin
                     if (!ccd_busy) begin
                        start_d  = 1'b1;
                        txData_d = RSP_ACK;
                     end else begin
                        txData_d = RSP_NAK;
                     end
                  end
                  CMD_SET_INTEG: begin
                     if ({argHi_q, argLo_q} != 16'd0) begin
                        integ_d  = {argHi_q, argLo_q};
                        txData_d = RSP_ACK;
                     end else begin
                        txData_d = RSP_NAK;
                     end
                  end
                  CMD_STOP: begin
                     stop_d   = 1'b1;
                     txData_d = RSP_ACK;
                  end
                  CMD_QUERY: begin
                     txData_d = RSP_QUERY_BASE | {7'd0, ccd_busy};
                  end
                  default: begin
                     txData_d = RSP_NAK;
                  end
               endcase
            end
         end
         ST_RESP: begin
            if (txFire) begin
               txValid_d = 1'b0;
               state_d   = ST_HUNT;
            end
         end
         default: begin
            state_d = ST_HUNT;
         end
      endcase

      // The timeout only fires on a cycle with no accepted byte, so it can override the case above.
      if (tmoExpired) begin
         state_d = ST_HUNT;
         err_d   = sat_inc8(err_q);
      end
   end

   assign rdy_d = accepts_rx(state_d);

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_HUNT;
         cmd_q     <= 8'h00;
         argHi_q   <= 8'h00;
         argLo_q   <= 8'h00;
         sum_q     <= 8'h00;
         csumOk_q  <= 1'b0;
         rdy_q     <= 1'b0;
         txData_q  <= 8'h00;
         txValid_q <= 1'b0;
         start_q   <= 1'b0;
         stop_q    <= 1'b0;
         integ_q   <= INTEG_DEFAULT;
         err_q     <= 8'h00;
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         argHi_q   <= argHi_d;
         argLo_q   <= argLo_d;
         sum_q     <= sum_d;
         csumOk_q  <= csumOk_d;
         rdy_q     <= rdy_d;
         txData_q  <= txData_d;
         txValid_q <= txValid_d;
         start_q   <= start_d;
         stop_q    <= stop_d;
         integ_q   <= integ_d;
         err_q     <= err_d;
      end
   end

   assign link.rx_data_ready = rdy_q;
   assign link.tx_data       = txData_q;
   assign link.tx_data_valid = txValid_q;
   assign ccd_start          = start_q;
   assign ccd_stop           = stop_q;
   assign integ_time         = integ_q;
   assign err_cnt            = err_q;

endmodule
